// File: rtl/mdio_mgmt_controller_pkg.sv
// Shared types and constants for the MDIO (Clause 22) PHY-side management controller.
// Holds the FSM state enum, opcode constants, field widths and the debug view.
package mdio_mgmt_controller_pkg;

    localparam int OP_W    = 2;
    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int TA_W    = 2;
    localparam int DATA_W  = 16;
    localparam int CNT_W   = 5;

    localparam logic [OP_W-1:0] OP_WRITE = 2'b01;
    localparam logic [OP_W-1:0] OP_READ  = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_WR_DATA,
        S_RD_DATA,
        S_DONE
    } mdio_state_e;

    typedef struct packed {
        mdio_state_e      state;
        logic [CNT_W-1:0] bit_cnt;
        logic             phyad_match;
    } mdio_dbg_t;

    // Counter value seen while the final bit of a field of the given width is sampled.
    function automatic logic [CNT_W-1:0] last_idx(input int width);
        return CNT_W'(width - 1);
    endfunction

endpackage

// File: rtl/mdio_mgmt_controller_shift_rx.sv
// mdio_shift_rx: serial-in shift register with a bit counter, shared by all frame fields.
// i_clear has priority over i_load so the final bit of a field can be consumed via o_data_next.
module mdio_shift_rx
    import mdio_mgmt_controller_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_bit,
    output logic [DATA_W-1:0] o_data_next,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_data  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_data  <= {r_data[DATA_W-2:0], i_bit};
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_data_next = {r_data[DATA_W-2:0], i_bit};
    assign o_count     = r_count;

endmodule

// File: rtl/mdio_mgmt_controller.sv
// PHY-side MDIO frame decoder: turns write frames into a register-file strobe, captures read data.
// Optional build macro MDIO_PHYAD_FILTER_EN discards frames whose PHYAD differs from PHY_ADDR.
module mdio_mgmt_controller
    import mdio_mgmt_controller_pkg::*;
#(
    parameter logic [PHYAD_W-1:0] PHY_ADDR = 5'd1
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               mdio_out,
    input  logic               mdio_oe,
    input  logic [DATA_W-1:0]  rd_data,
    output logic               mdio_done,
    output logic [DATA_W-1:0]  mdio_in,
    output logic [REGAD_W-1:0] addr,
    output logic [DATA_W-1:0]  wr_data,
    output logic               wr_stb,
    output mdio_dbg_t          dbg
);

    mdio_state_e         r_state;
    mdio_state_e         w_next_state;
    logic [OP_W-1:0]     r_op;
    logic                r_phyad_match;
    logic [REGAD_W-1:0]  r_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic [DATA_W-1:0]   r_mdio_in;

    logic                w_clear;
    logic                w_load;
    logic                w_ld_op;
    logic                w_ld_match;
    logic                w_ld_addr;
    logic                w_ld_wr;
    logic                w_ld_rd;
    logic [DATA_W-1:0]   w_rx_next;
    logic [CNT_W-1:0]    w_rx_count;
    logic                w_phy_match;
    logic                w_phy_ok;
    logic                w_op_valid;
    logic                w_is_write;

    mdio_shift_rx u_shift_rx (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_load      (w_load),
        .i_bit       (mdio_out),
        .o_data_next (w_rx_next),
        .o_count     (w_rx_count)
    );

    assign w_phy_match = (w_rx_next[PHYAD_W-1:0] == PHY_ADDR);
    assign w_op_valid  = (w_rx_next[OP_W-1:0] == OP_WRITE) || (w_rx_next[OP_W-1:0] == OP_READ);
    assign w_is_write  = (r_op == OP_WRITE);

`ifdef MDIO_PHYAD_FILTER_EN
    assign w_phy_ok = w_phy_match;
`else
    assign w_phy_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_op          <= '0;
            r_phyad_match <= 1'b0;
            r_addr        <= '0;
            r_wr_data     <= '0;
            r_mdio_in     <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_ld_op)    r_op          <= w_rx_next[OP_W-1:0];
            if (w_ld_match) r_phyad_match <= w_phy_match;
            if (w_ld_addr)  r_addr        <= w_rx_next[REGAD_W-1:0];
            if (w_ld_wr)    r_wr_data     <= w_rx_next;
            if (w_ld_rd)    r_mdio_in     <= rd_data;
        end
    end

    // Each field state shifts until its last bit, then clears the counter and hands over.
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_load       = 1'b0;
        w_ld_op      = 1'b0;
        w_ld_match   = 1'b0;
        w_ld_addr    = 1'b0;
        w_ld_wr      = 1'b0;
        w_ld_rd      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_clear = 1'b1;
                if (mdio_oe && !mdio_out) w_next_state = S_START;
            end
            S_START: begin
                w_clear = 1'b1;
                if (!mdio_oe)     w_next_state = S_IDLE;
                else if (mdio_out) w_next_state = S_OP;
            end
            S_OP: begin
                if (!mdio_oe) begin
                    w_clear      = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_rx_count == last_idx(OP_W)) begin
                    w_clear      = 1'b1;
                    w_ld_op      = 1'b1;
                    w_next_state = w_op_valid ? S_PHYAD : S_IDLE;
                end else begin
                    w_load = 1'b1;
                end
            end
            S_PHYAD: begin
                if (!mdio_oe) begin
                    w_clear      = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_rx_count == last_idx(PHYAD_W)) begin
                    w_clear      = 1'b1;
                    w_ld_match   = 1'b1;
                    w_next_state = w_phy_ok ? S_REGAD : S_IDLE;
                end else begin
                    w_load = 1'b1;
                end
            end
            S_REGAD: begin
                if (!mdio_oe) begin
                    w_clear      = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_rx_count == last_idx(REGAD_W)) begin
                    w_clear      = 1'b1;
                    w_ld_addr    = 1'b1;
                    w_next_state = S_TA;
                end else begin
                    w_load = 1'b1;
                end
            end
            S_TA: begin
                // The manager releases the line for reads, so only writes can abort here.
                if (w_is_write && !mdio_oe) begin
                    w_clear      = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_rx_count == last_idx(TA_W)) begin
                    w_clear = 1'b1;
                    if (w_is_write) begin
                        w_next_state = S_WR_DATA;
                    end else begin
                        w_ld_rd      = 1'b1;
                        w_next_state = S_RD_DATA;
                    end
                end else begin
                    w_load = 1'b1;
                end
            end
            S_WR_DATA: begin
                if (!mdio_oe) begin
                    w_clear      = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_rx_count == last_idx(DATA_W)) begin
                    w_clear      = 1'b1;
                    w_ld_wr      = 1'b1;
                    w_next_state = S_DONE;
                end else begin
                    w_load = 1'b1;
                end
            end
            S_RD_DATA: begin
                if (w_rx_count == last_idx(DATA_W)) begin
                    w_clear      = 1'b1;
                    w_next_state = S_DONE;
                end else begin
                    w_load = 1'b1;
                end
            end
            S_DONE: begin
                w_clear      = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_clear      = 1'b1;
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign mdio_done = (r_state == S_DONE);
    assign wr_stb    = (r_state == S_DONE) && w_is_write;
    assign mdio_in   = r_mdio_in;
    assign addr      = r_addr;
    assign wr_data   = r_wr_data;

    assign dbg.state       = r_state;
    assign dbg.bit_cnt     = w_rx_count;
    assign dbg.phyad_match = r_phyad_match;

endmodule

// File: tb/tb_mdio_mgmt_controller.sv
// Self-checking bench for mdio_mgmt_controller: frame-level model, per-cycle compare, directed pins.
// Honors MDIO_PHYAD_FILTER_EN the same way as the design build.
`timescale 1ns/1ps
module tb_mdio_mgmt_controller;
    import mdio_mgmt_controller_pkg::*;

    localparam logic [4:0] TB_PHY_ADDR = 5'd1;

    logic        clk = 1'b0;
    logic        reset;
    logic        mdio_out;
    logic        mdio_oe;
    logic [15:0] rd_data;
    logic        mdio_done;
    logic [15:0] mdio_in;
    logic [4:0]  addr;
    logic [15:0] wr_data;
    logic        wr_stb;
    mdio_dbg_t   dbg;

    mdio_mgmt_controller #(.PHY_ADDR(TB_PHY_ADDR)) dut (
        .clk       (clk),
        .reset     (reset),
        .mdio_out  (mdio_out),
        .mdio_oe   (mdio_oe),
        .rd_data   (rd_data),
        .mdio_done (mdio_done),
        .mdio_in   (mdio_in),
        .addr      (addr),
        .wr_data   (wr_data),
        .wr_stb    (wr_stb),
        .dbg       (dbg)
    );

    always #5 clk = ~clk;

    // ---------------- register file stand-in (static contents) ----------------
    logic [15:0] regfile [32];
    assign rd_data = regfile[addr];

    // ---------------- model state and scoreboard ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    int          edges    = 0;
    int          stb_cnt  = 0;
    int          done_cnt = 0;
    int          st_edge  = 0;
    int          stb_edge = 0;
    logic        chk_en   = 1'b0;
    logic        exp_done, exp_stb;
    logic [4:0]  exp_addr;
    logic [15:0] exp_wr_data, exp_mdio_in;
    logic [21:0] exp_q[$];

    always @(posedge clk) edges++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [21:0] got;
            check("mdio_done", 32'(mdio_done), 32'(exp_done));
            check("wr_stb",    32'(wr_stb),    32'(exp_stb));
            check("addr",      32'(addr),      32'(exp_addr));
            check("wr_data",   32'(wr_data),   32'(exp_wr_data));
            check("mdio_in",   32'(mdio_in),   32'(exp_mdio_in));
            if (mdio_done === 1'b1) begin
                check("pending_frames", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    got = {wr_stb, addr, (wr_stb === 1'b1) ? wr_data : mdio_in};
                    check("frame_result", 32'(got), 32'(exp_q.pop_front()));
                end
            end
            if (wr_stb === 1'b1) begin
                stb_cnt++;
                stb_edge = edges;
            end
            if (mdio_done === 1'b1) done_cnt++;
        end
    end

    // ---------------- driver ----------------
    task automatic drive_bit(input logic b, input logic oe);
        mdio_out = b;
        mdio_oe  = oe;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_done    = 1'b0;
        exp_stb     = 1'b0;
        exp_addr    = '0;
        exp_wr_data = '0;
        exp_mdio_in = '0;
    endtask

    // Drives one frame; bit i=0 is the ST 0-bit. abort_at drops mdio_oe on that bit,
    // reset_at pulses reset on that bit. Model outputs are updated after each sampled edge.
    task automatic send_frame(input logic [1:0] op, input logic [4:0] phyad, input logic [4:0] regad,
                              input logic [15:0] data, input int pre, input int abort_at, input int reset_at);
        logic [31:0] bits;
        logic        b, oe, is_wr, is_rd, filtered, aborted, reset_hit;
        int          stop;
        bits      = {2'b01, op, phyad, regad, 2'b10, data};
        is_wr     = (op == OP_WRITE);
        is_rd     = (op == OP_READ);
`ifdef MDIO_PHYAD_FILTER_EN
        filtered  = (phyad != TB_PHY_ADDR);
`else
        filtered  = 1'b0;
`endif
        stop      = 31;
        if (!is_wr && !is_rd) stop = 3;
        else if (filtered)    stop = 8;
        aborted   = 1'b0;
        reset_hit = 1'b0;
        if (reset_at >= 0 && reset_at <= stop) begin
            stop      = reset_at;
            reset_hit = 1'b1;
        end else if (abort_at >= 1 && abort_at <= stop) begin
            stop    = abort_at;
            aborted = 1'b1;
        end
        for (int p = 0; p < pre; p++) drive_bit(1'b1, 1'b1);
        for (int i = 0; i <= stop; i++) begin
            b  = bits[31-i];
            oe = 1'b1;
            if (is_rd && i >= 14) begin
                b  = 1'($urandom_range(0, 1));
                oe = 1'b0;
            end
            if (aborted && i == stop) oe = 1'b0;
            if (reset_hit && i == stop) reset = 1'b1;
            drive_bit(b, oe);
            if (i == 0) st_edge = edges;
            if (reset_hit && i == stop) begin
                reset = 1'b0;
                clear_model();
            end else if (!(aborted && i == stop)) begin
                if (i == 13) exp_addr = regad;
                if (i == 15 && is_rd) exp_mdio_in = regfile[regad];
                if (i == 31) begin
                    exp_done = 1'b1;
                    exp_stb  = is_wr;
                    if (is_wr) exp_wr_data = data;
                    exp_q.push_back({is_wr, regad, is_wr ? data : regfile[regad]});
                end
            end
        end
        if (stop == 31 && !aborted && !reset_hit) begin
            drive_bit(1'b1, 1'b1);
            exp_done = 1'b0;
            exp_stb  = 1'b0;
        end else begin
            repeat (2) drive_bit(1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s_stb, s_done;
        for (int k = 0; k < 32; k++) regfile[k] = 16'($urandom);
        regfile[8] = 16'hFEED;
        regfile[7] = 16'hCAFE;

        reset    = 1'b1;
        mdio_out = 1'b1;
        mdio_oe  = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        clear_model();
        chk_en = 1'b1;
        check("reset_state", 32'(dbg.state), 32'(S_IDLE));
        check("reset_bitcnt", 32'(dbg.bit_cnt), 32'd0);
        reset = 1'b0;
        repeat (3) drive_bit(1'($urandom_range(0, 1)), 1'b0);

        // Write PHYAD=1 REGAD=5 data ABCD
        s_stb = stb_cnt; s_done = done_cnt;
        send_frame(OP_WRITE, 5'd1, 5'd5, 16'hABCD, 2, -1, -1);
        check("wr1_addr", 32'(addr), 32'd5);
        check("wr1_data", 32'(wr_data), 32'hABCD);
        check("wr1_stb_pulses", 32'(stb_cnt - s_stb), 32'd1);
        check("wr1_done_pulses", 32'(done_cnt - s_done), 32'd1);
        // ST 0-bit is driven in the cycle ending at the sampling edge; the strobe occupies the
        // cycle starting 31 edges later, i.e. 32 cycles after the ST bit's cycle.
        check("wr1_latency_edges", 32'(stb_edge - st_edge), 32'd31);

        // Read PHYAD=1 REGAD=8
        s_stb = stb_cnt; s_done = done_cnt;
        send_frame(OP_READ, 5'd1, 5'd8, 16'h0000, 1, -1, -1);
        check("rd1_addr", 32'(addr), 32'd8);
        check("rd1_mdio_in", 32'(mdio_in), 32'hFEED);
        check("rd1_done_pulses", 32'(done_cnt - s_done), 32'd1);
        check("rd1_stb_pulses", 32'(stb_cnt - s_stb), 32'd0);

        // Write REGAD=31 FFFF, back-to-back after the previous DONE
        s_stb = stb_cnt;
        send_frame(OP_WRITE, 5'd1, 5'd31, 16'hFFFF, 0, -1, -1);
        check("wr31_addr", 32'(addr), 32'd31);
        check("wr31_data", 32'(wr_data), 32'hFFFF);
        check("wr31_stb_pulses", 32'(stb_cnt - s_stb), 32'd1);

        // Read from foreign PHYAD=15 REGAD=7
        s_done = done_cnt;
        send_frame(OP_READ, 5'd15, 5'd7, 16'h0000, 2, -1, -1);
`ifdef MDIO_PHYAD_FILTER_EN
        check("phy15_addr", 32'(addr), 32'd31);
        check("phy15_mdio_in", 32'(mdio_in), 32'hFEED);
        check("phy15_done_pulses", 32'(done_cnt - s_done), 32'd0);
`else
        check("phy15_addr", 32'(addr), 32'd7);
        check("phy15_mdio_in", 32'(mdio_in), 32'hCAFE);
        check("phy15_done_pulses", 32'(done_cnt - s_done), 32'd1);
`endif

        // Opcode 00, then mdio_oe dropped mid-REGAD, then a clean write
        s_stb = stb_cnt; s_done = done_cnt;
        send_frame(2'b00, 5'd1, 5'd3, 16'h5555, 1, -1, -1);
        send_frame(OP_WRITE, 5'd1, 5'd20, 16'h9999, 1, 11, -1);
        check("bad_frames_stb", 32'(stb_cnt - s_stb), 32'd0);
        check("bad_frames_done", 32'(done_cnt - s_done), 32'd0);
`ifdef MDIO_PHYAD_FILTER_EN
        check("bad_frames_addr", 32'(addr), 32'd31);
`else
        check("bad_frames_addr", 32'(addr), 32'd7);
`endif
        send_frame(OP_WRITE, 5'd1, 5'd12, 16'h1234, 1, -1, -1);
        check("wr12_addr", 32'(addr), 32'd12);
        check("wr12_data", 32'(wr_data), 32'h1234);
        check("wr12_stb_pulses", 32'(stb_cnt - s_stb), 32'd1);

        // Reset in the middle of a write data phase
        s_stb = stb_cnt;
        send_frame(OP_WRITE, 5'd1, 5'd9, 16'h0F0F, 1, -1, 20);
        check("midreset_addr", 32'(addr), 32'd0);
        check("midreset_wr_data", 32'(wr_data), 32'd0);
        check("midreset_stb_pulses", 32'(stb_cnt - s_stb), 32'd0);

        // Randomized frames
        for (int f = 0; f < 60; f++) begin
            logic [1:0]  op;
            logic [4:0]  phyad, regad;
            logic [15:0] data;
            int r, k, ab, rs;
            r  = int'($urandom_range(0, 9));
            op = (r < 4) ? OP_WRITE : (r < 8) ? OP_READ : (r == 8) ? 2'b00 : 2'b11;
            phyad = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : TB_PHY_ADDR;
            regad = 5'($urandom_range(0, 31));
            data  = 16'($urandom);
            ab = -1;
            rs = -1;
            k  = int'($urandom_range(0, 9));
            if (k == 0)
                ab = (op == OP_WRITE) ? int'($urandom_range(1, 31)) :
                     (op == OP_READ)  ? int'($urandom_range(1, 13)) : int'($urandom_range(1, 3));
            else if (k == 1)
                rs = int'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) drive_bit(1'($urandom_range(0, 1)), 1'b0);
            send_frame(op, phyad, regad, data, int'($urandom_range(0, 3)), ab, rs);
        end

        repeat (3) drive_bit(1'b1, 1'b0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
